io_port_bank: RTL and testbench

//  Parametrised bank of bidirectional pad ports for the J1 core. It succeeds the fixed 8-bit

---
 rtl/io_port_bank.sv | 217 +++++++++++++++++++++
 tb/tb_io_port_bank.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_port_bank.sv
// -----------------------------------------------------------------------------
// io_port_bank
// Bank of NPORTS bidirectional pad ports on the J1 IO bus. Each port has its
// own output, direction, synchronised input, interrupt mask, pending and edge
// select registers, plus a write-only atomic toggle.
//
// Register map per port (io_addr = {port, reg}):
//   0 OUT    rw   pad output values
//   1 DIR    rw   1 = output (pad_oeb is the inverse)
//   2 IN     ro   pad inputs after the 2-FF synchroniser
//   3 MASK   rw   interrupt enable per bit
//   4 PEND   r/w1c edge-detect pending bits
//   5 EDGE   rw   0 = rising, 1 = falling per bit
//   6 TOGGLE wo   OUT <= OUT ^ io_din, reads 0
//   7 --     reserved, reads 0, writes ignored
// Port indices >= NPORTS ignore writes and read as 0 (io_rdvalid still pulses).
//
// Ports:
//   boardClk   system clock, rising edge
//   reset_n    synchronous active-low reset
//   io_wr      write strobe (one cycle per access)
//   io_rd      read strobe (one cycle per access)
//   io_addr    {port index, register index}
//   io_din     write data
//   io_dout    registered read data, held until the next read
//   io_rdvalid one-cycle pulse the cycle after io_rd
//   pad_in     raw asynchronous pad inputs, port p on bits [p*WIDTH +: WIDTH]
//   pad_out    pad output values
//   pad_oeb    pad output enables, active low
//   irq        OR of all per-port interrupts
//   irq_port   per-port |(PEND & MASK)
//
// NPORTS must be at least 2 so the port-index field of io_addr is non-empty.
// -----------------------------------------------------------------------------
module io_port_bank #(
    parameter  int unsigned NPORTS = 2,
    parameter  int unsigned WIDTH  = 8,
    localparam int unsigned AW     = $clog2(NPORTS) + 3
) (
    input  logic                      boardClk,
    input  logic                      reset_n,
    input  logic                      io_wr,
    input  logic                      io_rd,
    input  logic [AW-1:0]             io_addr,
    input  logic [WIDTH-1:0]          io_din,
    output logic [WIDTH-1:0]          io_dout,
    output logic                      io_rdvalid,
    input  logic [NPORTS*WIDTH-1:0]   pad_in,
    output logic [NPORTS*WIDTH-1:0]   pad_out,
    output logic [NPORTS*WIDTH-1:0]   pad_oeb,
    output logic                      irq,
    output logic [NPORTS-1:0]         irq_port
);

    localparam int unsigned PW = AW - 3;

    localparam logic [2:0] REG_OUT    = 3'd0;
    localparam logic [2:0] REG_DIR    = 3'd1;
    localparam logic [2:0] REG_IN     = 3'd2;
    localparam logic [2:0] REG_MASK   = 3'd3;
    localparam logic [2:0] REG_PEND   = 3'd4;
    localparam logic [2:0] REG_EDGE   = 3'd5;
    localparam logic [2:0] REG_TOGGLE = 3'd6;

    // Per-port register state. Direction is stored inverted so pad_oeb is a
    // flop output and resets to all-ones (all pads inputs).
    logic [NPORTS-1:0][WIDTH-1:0] r_out;
    logic [NPORTS-1:0][WIDTH-1:0] r_oeb;
    logic [NPORTS-1:0][WIDTH-1:0] r_mask;
    logic [NPORTS-1:0][WIDTH-1:0] r_pend;
    logic [NPORTS-1:0][WIDTH-1:0] r_edge;

    // Input synchroniser (s1, s2) plus one history stage (s3) for edge detect.
    logic [NPORTS-1:0][WIDTH-1:0] r_s1;
    logic [NPORTS-1:0][WIDTH-1:0] r_s2;
    logic [NPORTS-1:0][WIDTH-1:0] r_s3;

    logic [WIDTH-1:0]             r_dout;
    logic                         r_rdvalid;
    logic [NPORTS-1:0]            r_irq_port;
    logic                         r_irq;

    logic [PW-1:0]                w_port;
    logic [2:0]                   w_reg;
    logic                         w_port_ok;

    logic [NPORTS-1:0][WIDTH-1:0] w_hit;
    logic [NPORTS-1:0][WIDTH-1:0] w_clr;
    logic [NPORTS-1:0][WIDTH-1:0] w_out_nxt;
    logic [NPORTS-1:0][WIDTH-1:0] w_oeb_nxt;
    logic [NPORTS-1:0][WIDTH-1:0] w_mask_nxt;
    logic [NPORTS-1:0][WIDTH-1:0] w_pend_nxt;
    logic [NPORTS-1:0][WIDTH-1:0] w_edge_nxt;
    logic [WIDTH-1:0]             w_rdata;
    logic [NPORTS-1:0]            w_irq_port_nxt;

    // Address decode.
    assign w_port    = io_addr[AW-1:3];
    assign w_reg     = io_addr[2:0];
    assign w_port_ok = (32'(w_port) < NPORTS);

    // Edge detect on the synchronised value against its previous sample.
    // EDGE only selects which polarity counts, so changing it never creates a hit.
    assign w_hit = (r_edge & r_s3 & ~r_s2) | (~r_edge & r_s2 & ~r_s3);

    // Register write decode and next-state computation.
    always_comb begin
        w_out_nxt  = r_out;
        w_oeb_nxt  = r_oeb;
        w_mask_nxt = r_mask;
        w_edge_nxt = r_edge;
        w_clr      = '0;
        for (int p = 0; p < NPORTS; p++) begin
            if (io_wr && w_port_ok && (w_port == PW'(p))) begin
                case (w_reg)
                    REG_OUT:    w_out_nxt[p]  = io_din;
                    REG_DIR:    w_oeb_nxt[p]  = ~io_din;
                    REG_MASK:   w_mask_nxt[p] = io_din;
                    REG_PEND:   w_clr[p]      = io_din;
                    REG_EDGE:   w_edge_nxt[p] = io_din;
                    REG_TOGGLE: w_out_nxt[p]  = r_out[p] ^ io_din;
                    default:    ;
                endcase
            end
        end
        // A new hit overrides a clear of the same bit in the same cycle.
        w_pend_nxt = (r_pend & ~w_clr) | w_hit;
    end

    // Read mux from current (pre-write) register values.
    always_comb begin
        w_rdata = '0;
        for (int p = 0; p < NPORTS; p++) begin
            if (w_port_ok && (w_port == PW'(p))) begin
                case (w_reg)
                    REG_OUT:  w_rdata = r_out[p];
                    REG_DIR:  w_rdata = ~r_oeb[p];
                    REG_IN:   w_rdata = r_s2[p];
                    REG_MASK: w_rdata = r_mask[p];
                    REG_PEND: w_rdata = r_pend[p];
                    REG_EDGE: w_rdata = r_edge[p];
                    default:  w_rdata = '0;
                endcase
            end
        end
    end

    // Per-port interrupt request from the current pending and mask state.
    always_comb begin
        w_irq_port_nxt = '0;
        for (int p = 0; p < NPORTS; p++) begin
            w_irq_port_nxt[p] = |(r_pend[p] & r_mask[p]);
        end
    end

    // Port configuration and pending state.
    always_ff @(posedge boardClk) begin
        if (!reset_n) begin
            r_out  <= '0;
            r_oeb  <= '1;
            r_mask <= '0;
            r_pend <= '0;
            r_edge <= '0;
        end else begin
            r_out  <= w_out_nxt;
            r_oeb  <= w_oeb_nxt;
            r_mask <= w_mask_nxt;
            r_pend <= w_pend_nxt;
            r_edge <= w_edge_nxt;
        end
    end

    // Input synchroniser and edge history.
    always_ff @(posedge boardClk) begin
        if (!reset_n) begin
            r_s1 <= '0;
            r_s2 <= '0;
            r_s3 <= '0;
        end else begin
            r_s1 <= pad_in;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    // Bus read response; a reset in the read cycle suppresses the response.
    always_ff @(posedge boardClk) begin
        if (!reset_n) begin
            r_dout    <= '0;
            r_rdvalid <= 1'b0;
        end else begin
            r_rdvalid <= io_rd;
            if (io_rd) begin
                r_dout <= w_rdata;
            end
        end
    end

    // Interrupt outputs, level style.
    always_ff @(posedge boardClk) begin
        if (!reset_n) begin
            r_irq_port <= '0;
            r_irq      <= 1'b0;
        end else begin
            r_irq_port <= w_irq_port_nxt;
            r_irq      <= |w_irq_port_nxt;
        end
    end

    assign io_dout    = r_dout;
    assign io_rdvalid = r_rdvalid;
    assign pad_out    = r_out;
    assign pad_oeb    = r_oeb;
    assign irq_port   = r_irq_port;
    assign irq        = r_irq;

endmodule

// File: tb/tb_io_port_bank.sv
// -----------------------------------------------------------------------------
// tb_io_port_bank
// Self-checking bench for io_port_bank with three ports so that an
// out-of-range port index is addressable. Directed scenarios are followed by
// randomized bus traffic, pad activity and resets; every cycle the outputs are
// compared against a behavioural model of the register bank.
// -----------------------------------------------------------------------------
module tb_io_port_bank;

    localparam int unsigned NP = 3;
    localparam int unsigned W  = 8;
    localparam int unsigned AW = $clog2(NP) + 3;
    localparam int unsigned NB = NP * W;

    logic              boardClk = 1'b0;
    logic              reset_n;
    logic              io_wr;
    logic              io_rd;
    logic [AW-1:0]     io_addr;
    logic [W-1:0]      io_din;
    logic [W-1:0]      io_dout;
    logic              io_rdvalid;
    logic [NB-1:0]     pad_in;
    logic [NB-1:0]     pad_out;
    logic [NB-1:0]     pad_oeb;
    logic              irq;
    logic [NP-1:0]     irq_port;

    always #5 boardClk = ~boardClk;

    io_port_bank #(.NPORTS(NP), .WIDTH(W)) dut (
        .boardClk   (boardClk),
        .reset_n    (reset_n),
        .io_wr      (io_wr),
        .io_rd      (io_rd),
        .io_addr    (io_addr),
        .io_din     (io_din),
        .io_dout    (io_dout),
        .io_rdvalid (io_rdvalid),
        .pad_in     (pad_in),
        .pad_out    (pad_out),
        .pad_oeb    (pad_oeb),
        .irq        (irq),
        .irq_port   (irq_port)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [W-1:0]  m_out  [NP];
    logic [W-1:0]  m_dir  [NP];
    logic [W-1:0]  m_mask [NP];
    logic [W-1:0]  m_pend [NP];
    logic [W-1:0]  m_edge [NP];
    logic [NB-1:0] hist[$];     // pad values sampled at past edges, [0] = newest
    logic [W-1:0]  m_dout;
    logic          m_rdvalid;
    logic [NP-1:0] m_irqp;
    logic          m_irq;

    task automatic m_reset();
        for (int p = 0; p < NP; p++) begin
            m_out[p] = '0; m_dir[p] = '0; m_mask[p] = '0; m_pend[p] = '0; m_edge[p] = '0;
        end
        hist.delete();
        repeat (3) hist.push_back('0);
        m_dout = '0; m_rdvalid = 1'b0; m_irqp = '0; m_irq = 1'b0;
    endtask

    function automatic logic [W-1:0] m_read(input int p, input int r);
        if (p >= NP) return '0;
        case (r)
            0: return m_out[p];
            1: return m_dir[p];
            2: return hist[1][p*W +: W];
            3: return m_mask[p];
            4: return m_pend[p];
            5: return m_edge[p];
            default: return '0;
        endcase
    endfunction

    // Advance the model by one rising clock edge with the given inputs.
    task automatic m_edge_step(input logic rst_n, input logic wr, input logic rd,
                               input int addr, input logic [W-1:0] din, input logic [NB-1:0] pad);
        int p;
        int r;
        logic [W-1:0] hit [NP];
        logic [W-1:0] clr;
        if (!rst_n) begin
            m_reset();
            return;
        end
        p = addr / 8;
        r = addr % 8;
        m_rdvalid = rd;
        if (rd) m_dout = m_read(p, r);
        m_irq = 1'b0;
        for (int q = 0; q < NP; q++) begin
            m_irqp[q] = |(m_pend[q] & m_mask[q]);
            if (m_irqp[q]) m_irq = 1'b1;
            for (int b = 0; b < W; b++) begin
                logic cur, prev;
                cur  = hist[1][q*W + b];
                prev = hist[2][q*W + b];
                hit[q][b] = m_edge[q][b] ? (prev && !cur) : (!prev && cur);
            end
        end
        clr = '0;
        if (wr && p < NP) begin
            case (r)
                0: m_out[p]  = din;
                1: m_dir[p]  = din;
                3: m_mask[p] = din;
                4: clr       = din;
                5: m_edge[p] = din;
                6: m_out[p]  = m_out[p] ^ din;
                default: ;
            endcase
        end
        for (int q = 0; q < NP; q++) begin
            m_pend[q] = (m_pend[q] & ~((q == p) ? clr : '0)) | hit[q];
        end
        hist.push_front(pad);
        void'(hist.pop_back());
    endtask

    function automatic logic [NB-1:0] m_pad_out();
        logic [NB-1:0] v;
        for (int q = 0; q < NP; q++) v[q*W +: W] = m_out[q];
        return v;
    endfunction

    function automatic logic [NB-1:0] m_pad_oeb();
        logic [NB-1:0] v;
        for (int q = 0; q < NP; q++) v[q*W +: W] = ~m_dir[q];
        return v;
    endfunction

    // ---------------- stimulus helpers ----------------
    logic [NB-1:0] pad = '0;

    task automatic cycle(input logic rst, input logic wr, input logic rd,
                         input int addr, input logic [W-1:0] din);
        @(negedge boardClk);
        reset_n = rst;
        io_wr   = wr;
        io_rd   = rd;
        io_addr = AW'(addr);
        io_din  = din;
        pad_in  = pad;
        @(posedge boardClk);
        m_edge_step(rst, wr, rd, addr, din, pad);
        #1;
        check("pad_out",    32'(pad_out),    32'(m_pad_out()));
        check("pad_oeb",    32'(pad_oeb),    32'(m_pad_oeb()));
        check("io_dout",    32'(io_dout),    32'(m_dout));
        check("io_rdvalid", 32'(io_rdvalid), 32'(m_rdvalid));
        check("irq_port",   32'(irq_port),   32'(m_irqp));
        check("irq",        32'(irq),        32'(m_irq));
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(1'b1, 1'b0, 1'b0, 0, '0);
    endtask

    task automatic wr(input int port, input int r, input logic [W-1:0] d);
        cycle(1'b1, 1'b1, 1'b0, port * 8 + r, d);
    endtask

    task automatic rd(input int port, input int r);
        cycle(1'b1, 1'b0, 1'b1, port * 8 + r, '0);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        reset_n = 1'b0; io_wr = 1'b0; io_rd = 1'b0; io_addr = '0; io_din = '0; pad_in = '0;
        m_reset();

        // Reset state and reads of a valid and an out-of-range port.
        cycle(1'b0, 1'b0, 1'b0, 0, '0);
        cycle(1'b0, 1'b0, 1'b0, 0, '0);
        check("rst_pad_oeb", 32'(pad_oeb), 32'({NB{1'b1}}));
        check("rst_irq", 32'(irq), 32'(0));
        for (int port = 0; port <= NP; port += NP) begin
            for (int r = 0; r < 8; r++) begin
                rd(port, r);
                check("rst_read", 32'(io_dout), 32'(0));
                check("rst_rdvalid", 32'(io_rdvalid), 32'(1));
            end
        end
        wr(NP, 0, 8'hFF);
        rd(NP, 0);
        check("bad_port_read", 32'(io_dout), 32'(0));

        // Direction, output and atomic toggle.
        wr(0, 1, 8'hF0);
        wr(0, 0, 8'hA5);
        wr(0, 6, 8'h0F);
        check("toggle_out", 32'(pad_out[7:0]), 32'(8'hAA));
        check("dir_oeb", 32'(pad_oeb[7:0]), 32'(8'h0F));
        rd(0, 6);
        check("toggle_reads0", 32'(io_dout), 32'(0));

        // Rising edge on bit 3 raises PEND and irq; W1C clears it.
        wr(0, 5, 8'h00);
        wr(0, 3, 8'h08);
        pad[3] = 1'b1;
        idle(4);
        check("irq_set", 32'(irq), 32'(1));
        rd(0, 2);
        check("in_bit3", 32'(io_dout[3]), 32'(1));
        rd(0, 4);
        check("pend_bit3", 32'(io_dout), 32'(8'h08));
        wr(0, 4, 8'h08);
        idle(2);
        check("irq_clr", 32'(irq), 32'(0));

        // Falling-edge select on bit 0: rising ignored, falling detected.
        wr(0, 5, 8'h01);
        pad[0] = 1'b1;
        idle(4);
        rd(0, 4);
        check("fall_no_rise", 32'(io_dout), 32'(0));
        pad[0] = 1'b0;
        idle(4);
        rd(0, 4);
        check("fall_hit", 32'(io_dout), 32'(8'h01));
        wr(0, 4, 8'hFF);

        // Hit and clear of bit 2 in the same cycle: set wins.
        pad[2] = 1'b1;
        idle(2);
        wr(0, 4, 8'h04);
        rd(0, 4);
        check("set_wins", 32'(io_dout), 32'(8'h04));

        // Reset during a read aborts it and clears state.
        wr(0, 3, 8'h04);
        idle(2);
        check("irq_before_rst", 32'(irq), 32'(1));
        cycle(1'b0, 1'b0, 1'b1, 4, '0);
        check("rst_rdvalid0", 32'(io_rdvalid), 32'(0));
        check("rst_irq0", 32'(irq), 32'(0));
        check("rst_out0", 32'(pad_out), 32'(0));
        check("rst_oeb1", 32'(pad_oeb), 32'({NB{1'b1}}));
        rd(0, 4);
        check("rst_pend0", 32'(io_dout), 32'(0));

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            logic rst, w, r;
            if ($urandom_range(0, 3) == 0) pad ^= NB'(1) << $urandom_range(0, NB - 1);
            rst = ($urandom_range(0, 249) != 0);
            w   = ($urandom_range(0, 2) == 0);
            r   = ($urandom_range(0, 2) == 0);
            cycle(rst, w, r, int'($urandom_range(0, (1 << AW) - 1)), W'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
